// File: rtl/barrel_thread_pc_sched.sv
// Purpose: round-robin barrel-thread scheduler that issues (tid, PC) to fetch and stores each thread's next PC.
// Latency: issue is registered one cycle after slot selection; a same-slot writeback is bypassed into that issue.
// Backpressure: none, one slot per cycle; a thread waits only on its own writeback. Option: BARREL_THREAD_BOOT_STRIDE_EN.
module barrel_thread_pc_sched #(
   parameter int                  NUM_THREADS  = 16,
   parameter int                  PC_WIDTH     = 12,
   parameter logic [PC_WIDTH-1:0] STARTUP_ADDR = '0,
`ifdef BARREL_THREAD_BOOT_STRIDE_EN
   parameter logic [PC_WIDTH-1:0] BOOT_STRIDE  = PC_WIDTH'('h100),
`endif
   localparam int                 TID_WIDTH    = $clog2(NUM_THREADS)
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic [NUM_THREADS-1:0] thread_en,
   input  logic                   wb_valid,
   input  logic [TID_WIDTH-1:0]   wb_tid,
   input  logic [PC_WIDTH-1:0]    wb_next_pc,
   output logic                   issue_valid,
   output logic [TID_WIDTH-1:0]   issue_tid,
   output logic [PC_WIDTH-1:0]    issue_pc,
   output logic [TID_WIDTH:0]     inflight_cnt,
   output logic                   err_stray_wb
);

   // Per-thread spacing of reset PCs; zero collapses every thread onto STARTUP_ADDR.
`ifdef BARREL_THREAD_BOOT_STRIDE_EN
   localparam logic [PC_WIDTH-1:0] STRIDE = BOOT_STRIDE;
`else
   localparam logic [PC_WIDTH-1:0] STRIDE = '0;
`endif
   localparam logic [TID_WIDTH-1:0] LAST_SLOT = TID_WIDTH'(NUM_THREADS - 1);
   localparam logic [TID_WIDTH:0]   NUM_T     = (TID_WIDTH + 1)'(NUM_THREADS);

   // Reset PC of thread i; the multiply wraps modulo 2^PC_WIDTH.
   function automatic logic [PC_WIDTH-1:0] boot_pc(input int i);
      return STARTUP_ADDR + PC_WIDTH'(i) * STRIDE;
   endfunction

   logic [TID_WIDTH-1:0]   slot_q;
   logic [PC_WIDTH-1:0]    pc_q [NUM_THREADS];
   logic [NUM_THREADS-1:0] ready_q;

   logic                   wb_in_range;
   logic                   wb_acc;
   logic                   wb_stray;
   logic                   bypass;
   logic                   issue_now;
   logic [PC_WIDTH-1:0]    wb_pc_al;
   logic [PC_WIDTH-1:0]    slot_pc;

   // Classify the writeback, apply the same-slot bypass and decide whether the current slot issues.
   always_comb begin
      wb_in_range = ({1'b0, wb_tid} < NUM_T);
      wb_pc_al    = wb_next_pc & ~PC_WIDTH'(3);
      wb_acc      = 1'b0;
      wb_stray    = 1'b0;
      if (wb_valid) begin
         if (wb_in_range && !ready_q[wb_tid])
            wb_acc = 1'b1;
         else
            wb_stray = 1'b1;
      end
      bypass    = wb_acc && (wb_tid == slot_q);
      slot_pc   = bypass ? wb_pc_al : pc_q[slot_q];
      issue_now = thread_en[slot_q] && (ready_q[slot_q] || bypass);
   end

   // Slot counter wraps by compare so non-power-of-two thread counts skip unused ids.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         slot_q <= '0;
      else if (slot_q == LAST_SLOT)
         slot_q <= '0;
      else
         slot_q <= slot_q + 1'b1;
   end

   // Fetch-slot registers; tid/pc track the slot even on bubbles so fetch can ignore them cheaply.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         issue_valid <= 1'b0;
         issue_tid   <= '0;
         issue_pc    <= '0;
      end else begin
         issue_valid <= issue_now;
         issue_tid   <= slot_q;
         issue_pc    <= slot_pc;
      end
   end

   // PC/ready store: accepted writeback restores ready, an issue in the same cycle clears it again.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < NUM_THREADS; i++) begin
            pc_q[i]    <= boot_pc(i);
            ready_q[i] <= 1'b1;
         end
      end else begin
         for (int i = 0; i < NUM_THREADS; i++) begin
            if (wb_acc && (wb_tid == TID_WIDTH'(i))) begin
               pc_q[i]    <= wb_pc_al;
               ready_q[i] <= 1'b1;
            end
            if (issue_now && (slot_q == TID_WIDTH'(i)))
               ready_q[i] <= 1'b0;
         end
      end
   end

   // In-flight count and sticky stray-writeback flag.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         inflight_cnt <= '0;
         err_stray_wb <= 1'b0;
      end else begin
         case ({issue_now, wb_acc})
            2'b10:   inflight_cnt <= inflight_cnt + 1'b1;
            2'b01:   inflight_cnt <= inflight_cnt - 1'b1;
            default: inflight_cnt <= inflight_cnt;
         endcase
         if (wb_stray)
            err_stray_wb <= 1'b1;
      end
   end

endmodule

// File: tb/tb_barrel_thread_pc_sched.sv
// Purpose: directed self-checking bench for barrel_thread_pc_sched (16-thread and 5-thread instances).
// Latency: expectations are queued when a cycle is driven and compared one clock later at the falling edge.
// Backpressure: none in the design; the bench plays the writeback stage with fixed return timing.
module tb_barrel_thread_pc_sched;

   logic        clk = 1'b0;
   logic        reset_n;

   logic [15:0] thread_en;
   logic        wb_valid;
   logic [3:0]  wb_tid;
   logic [11:0] wb_next_pc;
   logic        issue_valid;
   logic [3:0]  issue_tid;
   logic [11:0] issue_pc;
   logic [4:0]  inflight_cnt;
   logic        err_stray_wb;

   logic [4:0]  en5;
   logic        wbv5;
   logic [2:0]  wbt5;
   logic [11:0] wbpc5;
   logic        v5;
   logic [2:0]  t5;
   logic [11:0] pc5;
   logic [3:0]  cnt5;
   logic        err5;

   int checks = 0;
   int errors = 0;
   int slot   = 0;
   int slot5  = 0;
   logic [11:0] mpc [16];

   typedef struct packed {
      logic        v;
      logic [4:0]  tid;
      logic [11:0] pc;
      logic [5:0]  cnt;
      logic        err;
   } exp_t;

   exp_t sb[$];

`ifdef BARREL_THREAD_BOOT_STRIDE_EN
   localparam logic [11:0] BOOT_STRIDE = 12'h100;
`else
   localparam logic [11:0] BOOT_STRIDE = 12'h000;
`endif

   barrel_thread_pc_sched dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .thread_en    (thread_en),
      .wb_valid     (wb_valid),
      .wb_tid       (wb_tid),
      .wb_next_pc   (wb_next_pc),
      .issue_valid  (issue_valid),
      .issue_tid    (issue_tid),
      .issue_pc     (issue_pc),
      .inflight_cnt (inflight_cnt),
      .err_stray_wb (err_stray_wb)
   );

   barrel_thread_pc_sched #(.NUM_THREADS(5)) dut5 (
      .clk          (clk),
      .reset_n      (reset_n),
      .thread_en    (en5),
      .wb_valid     (wbv5),
      .wb_tid       (wbt5),
      .wb_next_pc   (wbpc5),
      .issue_valid  (v5),
      .issue_tid    (t5),
      .issue_pc     (pc5),
      .inflight_cnt (cnt5),
      .err_stray_wb (err5)
   );

   always #5 clk = ~clk;

   function automatic logic [11:0] boot_pc(input int i);
      return 12'(i) * BOOT_STRIDE;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Pulse reset between clock edges; outputs must clear before any rising edge.
   task automatic do_reset();
      @(negedge clk);
      reset_n  = 1'b0;
      wb_valid = 1'b0;
      wbv5     = 1'b0;
      #2;
      check("rst_valid", issue_valid, 0);
      check("rst_tid", issue_tid, 0);
      check("rst_pc", issue_pc, 0);
      check("rst_inflight", inflight_cnt, 0);
      check("rst_err", err_stray_wb, 0);
      check("rst5_valid", v5, 0);
      check("rst5_err", err5, 0);
      @(negedge clk);
      reset_n = 1'b1;
      slot    = 0;
      slot5   = 0;
   endtask

   task automatic tick(input logic wv, input int wt, input logic [11:0] wp,
                       input logic ev, input int et, input logic [11:0] ep, input int ec, input logic ee);
      exp_t e;
      exp_t got;
      wb_valid   = wv;
      wb_tid     = 4'(wt);
      wb_next_pc = wp;
      e = '{v: ev, tid: 5'(et), pc: ep, cnt: 6'(ec), err: ee};
      sb.push_back(e);
      @(posedge clk);
      @(negedge clk);
      wb_valid = 1'b0;
      slot     = (slot + 1) % 16;
      got = sb.pop_front();
      check("valid", issue_valid, got.v);
      check("tid", issue_tid, got.tid);
      check("pc", issue_pc, got.pc);
      check("inflight", inflight_cnt, got.cnt);
      check("err", err_stray_wb, got.err);
   endtask

   task automatic tick5(input logic wv, input int wt, input logic [11:0] wp,
                        input logic ev, input int et, input logic [11:0] ep, input int ec, input logic ee);
      exp_t e;
      exp_t got;
      wbv5  = wv;
      wbt5  = 3'(wt);
      wbpc5 = wp;
      e = '{v: ev, tid: 5'(et), pc: ep, cnt: 6'(ec), err: ee};
      sb.push_back(e);
      @(posedge clk);
      @(negedge clk);
      wbv5  = 1'b0;
      slot5 = (slot5 + 1) % 5;
      got = sb.pop_front();
      check("n5_valid", v5, got.v);
      check("n5_tid", t5, got.tid);
      check("n5_pc", pc5, got.pc);
      check("n5_inflight", cnt5, got.cnt);
      check("n5_err", err5, got.err);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      reset_n    = 1'b1;
      thread_en  = 16'hFFFF;
      wb_valid   = 1'b0;
      wb_tid     = '0;
      wb_next_pc = '0;
      en5        = '0;
      wbv5       = 1'b0;
      wbt5       = '0;
      wbpc5      = '0;

      // Cold start: every thread issues once at its boot PC, then the pipe is full.
      do_reset();
      for (int t = 0; t < 16; t++) tick(0, 0, 12'h0, 1, t, boot_pc(t), t + 1, 0);
      tick(0, 0, 12'h0, 0, 0, boot_pc(0), 16, 0);

      // Steady state: each slot's thread returns pc+4 exactly in its own slot (bypass).
      for (int t = 0; t < 16; t++) mpc[t] = boot_pc(t);
      for (int n = 0; n < 48; n++) begin
         int s;
         s = slot;
         mpc[s] = mpc[s] + 12'd4;
         tick(1, s, mpc[s], 1, s, mpc[s], 16, 0);
      end

      // Park everything; thread 7 returns while parked, then a second return for it is stray.
      thread_en = 16'h0000;
      tick(1, 7, 12'h123, 0, slot, mpc[slot], 15, 0);
      tick(1, 7, 12'h200, 0, slot, mpc[slot], 15, 1);
      thread_en = 16'h0080;
      while (slot != 7) tick(0, 0, 12'h0, 0, slot, mpc[slot], 15, 1);
      tick(0, 0, 12'h0, 1, 7, 12'h120, 16, 1);

      // Reset mid-operation clears the flag and restores every boot PC.
      do_reset();
      thread_en = 16'hFFFF;
      for (int t = 0; t < 16; t++) tick(0, 0, 12'h0, 1, t, boot_pc(t), t + 1, 0);

      // Single enabled thread: same-slot return reissues, early return idles one cycle.
      do_reset();
      thread_en = 16'h0001;
      tick(0, 0, 12'h0, 1, 0, boot_pc(0), 1, 0);
      for (int s = 1; s < 16; s++) tick(0, 0, 12'h0, 0, s, boot_pc(s), 1, 0);
      tick(1, 0, 12'h010, 1, 0, 12'h010, 1, 0);
      for (int s = 1; s < 15; s++) tick(0, 0, 12'h0, 0, s, boot_pc(s), 1, 0);
      tick(1, 0, 12'h021, 0, 15, boot_pc(15), 0, 0);
      tick(0, 0, 12'h0, 1, 0, 12'h020, 1, 0);

      // Five threads: wrap 4->0, misaligned return aligned, out-of-range tid flagged.
      do_reset();
      en5 = 5'b11111;
      for (int t = 0; t < 5; t++) tick5(0, 0, 12'h0, 1, t, boot_pc(t), t + 1, 0);
      tick5(0, 0, 12'h0, 0, 0, boot_pc(0), 5, 0);
      tick5(0, 0, 12'h0, 0, 1, boot_pc(1), 5, 0);
      tick5(1, 2, 12'h0A7, 1, 2, 12'h0A4, 5, 0);
      tick5(1, 6, 12'h040, 0, 3, boot_pc(3), 5, 1);
      tick5(0, 0, 12'h0, 0, 4, boot_pc(4), 5, 1);
      tick5(0, 0, 12'h0, 0, 0, boot_pc(0), 5, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
